// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, transaction record, requester ids and FSM state codes
package mem_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_BITS = 128;
  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam int MEM_TIMEOUT = 255;
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  typedef enum logic {REQ_IC = 1'b0, REQ_DC = 1'b1} requester_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic we;
    logic [LINE_BITS-1:0] wdata;
  } mem_txn_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick, the requester that did not own last wins a tie
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  requester_e last_owner,
  output logic       valid,
  output requester_e winner
);
  assign valid = |req;
  assign winner = requester_e'(req[1] && !(req[0] && last_owner == REQ_DC));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between icache refills and dcache refill/write-back
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_req,
  input  logic [ADDR_W-1:0]    ic_addr,
  output logic                 ic_gnt,
  output logic                 ic_rvalid,
  output logic [LINE_BITS-1:0] ic_rdata,
  output logic                 ic_err,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [ADDR_W-1:0]    dc_addr,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic                 dc_gnt,
  output logic                 dc_rvalid,
  output logic [LINE_BITS-1:0] dc_rdata,
  output logic                 dc_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [LINE_BITS-1:0] mem_rdata
);
  logic [1:0] state;
  requester_e owner, last_owner, pick;
  logic pick_valid, pick_ic, own_dc, done;
  logic [ADDR_W-1:0] pick_addr;
  logic [CNT_W-1:0] cnt;
  mem_txn_t txn;
  rr_arb2 u_arb (.req({dc_req, ic_req}), .last_owner(last_owner), .valid(pick_valid), .winner(pick));
  assign pick_ic = pick == REQ_IC;
  assign pick_addr = pick_ic ? ic_addr : dc_addr;
  assign own_dc = owner == REQ_DC;
  assign done = mem_rvalid || cnt == CNT_W'(MEM_TIMEOUT - 1);
  assign mem_addr = txn.addr;
  assign mem_we = txn.we;
  assign mem_wdata = txn.wdata;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= REQ_IC;
      last_owner <= REQ_DC;
      txn <= '0;
      cnt <= '0;
      mem_req <= 1'b0;
      ic_gnt <= 1'b0;
      dc_gnt <= 1'b0;
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      ic_rdata <= '0;
      dc_rdata <= '0;
      ic_err <= 1'b0;
      dc_err <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      ic_gnt <= 1'b0;
      dc_gnt <= 1'b0;
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      ic_rdata <= '0;
      dc_rdata <= '0;
      ic_err <= 1'b0;
      dc_err <= 1'b0;
      case (state)
        IDLE: if (pick_valid) begin
          state <= ISSUE;
          owner <= pick;
          last_owner <= pick;
          txn.addr <= pick_addr & {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};
          txn.we <= !pick_ic && dc_we;
          txn.wdata <= pick_ic ? '0 : dc_wdata;
          mem_req <= 1'b1;
          ic_gnt <= pick_ic;
          dc_gnt <= !pick_ic;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            state <= RESP;
            ic_rvalid <= !own_dc;
            dc_rvalid <= own_dc;
            ic_rdata <= !own_dc && mem_rvalid ? mem_rdata : '0;
            dc_rdata <= own_dc && mem_rvalid ? mem_rdata : '0;
            ic_err <= !own_dc && !mem_rvalid;
            dc_err <= own_dc && !mem_rvalid;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  a_gnt_excl: assert property (@(posedge clk) disable iff (!rst) !(ic_gnt && dc_gnt));
  a_rv_excl: assert property (@(posedge clk) disable iff (!rst) !(ic_rvalid && dc_rvalid));
  a_rv_wait: assert property (@(posedge clk) disable iff (!rst) mem_rvalid |-> state == WAIT);
  a_ic_hold: assert property (@(posedge clk) disable iff (!rst) ic_req && !ic_gnt |=> ic_req || ic_gnt);
  a_dc_hold: assert property (@(posedge clk) disable iff (!rst) dc_req && !dc_gnt |=> dc_req || dc_gnt);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and randomized rounds against a transaction-level model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, mem_rvalid = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0, dc_addr = '0;
  logic [LINE_BITS-1:0] dc_wdata = '0, mem_rdata = '0;
  logic ic_gnt, ic_rvalid, ic_err, dc_gnt, dc_rvalid, dc_err, mem_req, mem_we;
  logic [LINE_BITS-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  typedef struct { bit dc; int cyc; logic req; logic [ADDR_W-1:0] addr; logic we; logic [LINE_BITS-1:0] wd; } gev_t;
  typedef struct { bit dc; int cyc; logic [LINE_BITS-1:0] rd; logic err; } rev_t;
  typedef struct { int lat; logic [LINE_BITS-1:0] line; } mp_t;
  typedef struct {
    bit dc; bit we; logic [ADDR_W-1:0] addr; logic [LINE_BITS-1:0] wd; int lat; logic [LINE_BITS-1:0] line;
    logic [ADDR_W-1:0] x_addr; bit x_we; logic [LINE_BITS-1:0] x_rdata; bit x_err; int x_dly;
  } vec_t;
  gev_t gq[$];
  rev_t rq[$];
  mp_t mplan[$];
  int cyc = 0, checks = 0, errors = 0, viol = 0, nreq = 0, mem_cd = 0, start = 0;
  logic [LINE_BITS-1:0] mem_line = '0;
  requester_e m_last = REQ_DC;
  vec_t vt[6];
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_err(ic_err),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid),
    .dc_rdata(dc_rdata), .dc_err(dc_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string name, input logic [LINE_BITS-1:0] act, input logic [LINE_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    mp_t p;
    @(negedge clk);
    cyc++;
    if (ic_gnt || dc_gnt) gq.push_back('{dc_gnt, cyc, mem_req, mem_addr, mem_we, mem_wdata});
    if (ic_rvalid || dc_rvalid) rq.push_back('{dc_rvalid, cyc, dc_rvalid ? dc_rdata : ic_rdata, dc_rvalid ? dc_err : ic_err});
    if ((ic_gnt && dc_gnt) || (ic_rvalid && dc_rvalid)) viol++;
    if ((!ic_rvalid && (ic_err || ic_rdata != '0)) || (!dc_rvalid && (dc_err || dc_rdata != '0))) viol++;
    if (mem_req) nreq++;
    if (ic_gnt) ic_req = 1'b0;
    if (dc_gnt) dc_req = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = mem_line;
      end
    end
    if (mem_req && rst) begin
      mem_cd = 0;
      if (mplan.size() > 0) begin
        p = mplan.pop_front();
        mem_cd = p.lat;
        mem_line = p.line;
      end
    end
  endtask
  task automatic collect(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (rq.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (rq.size() < n) begin
      errors++;
      $display("FAIL %s responses: got %0d expected %0d", name, rq.size(), n);
    end
    repeat (3) tick();
  endtask
  task automatic drive(input bit icr, input bit dcr, input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                       input bit we, input logic [LINE_BITS-1:0] wd);
    ic_req = icr;
    dc_req = dcr;
    ic_addr = ia;
    dc_addr = da;
    dc_we = we;
    dc_wdata = wd;
    start = cyc;
  endtask
  task automatic clear_logs();
    gq.delete();
    rq.delete();
    nreq = 0;
  endtask
  task automatic chk_quiet(input string name);
    chk({name, " ctl"}, {ic_gnt, ic_rvalid, ic_err, dc_gnt, dc_rvalid, dc_err, mem_req, mem_we}, '0);
    chk({name, " data"}, ic_rdata | dc_rdata | mem_wdata, '0);
    chk({name, " addr"}, mem_addr, '0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{0, 0, 32'h0000_1234, '0, 3, {16{8'hA5}}, 32'h0000_1230, 0, {16{8'hA5}}, 0, 4};
    vt[1] = '{1, 1, 32'h8000_0010, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 2, {16{8'h11}}, 32'h8000_0010, 1, '0, 0, 3};
    vt[2] = '{1, 0, 32'hFFFF_FFFF, '0, 1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 32'hFFFF_FFF0, 0,
              128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 2};
    vt[3] = '{0, 0, 32'h0000_000F, '0, MEM_TIMEOUT, {16{8'h5C}}, 32'h0000_0000, 0, {16{8'h5C}}, 0, MEM_TIMEOUT + 1};
    vt[4] = '{1, 0, 32'h0000_4444, '0, 0, {16{8'hEE}}, 32'h0000_4440, 0, '0, 1, MEM_TIMEOUT + 1};
    vt[5] = '{0, 0, 32'hCAFE_BABE, '0, 5, {16{8'h3C}}, 32'hCAFE_BAB0, 0, {16{8'h3C}}, 0, 6};
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_quiet("reset");
    clear_logs();
    for (int r = 0; r < 2; r++) begin
      drive(1, 1, 32'h0000_0100, 32'h0000_0200, 0, '0);
      mplan.push_back('{1, {16{8'h01}}});
      mplan.push_back('{1, {16{8'h02}}});
      collect($sformatf("cont%0d", r), 2, 40);
      chk($sformatf("cont%0d first is ic", r), gq[0].dc, 0);
      chk($sformatf("cont%0d second is dc", r), gq[1].dc, 1);
      chk($sformatf("cont%0d gnt latency", r), gq[0].cyc - start, 1);
      chk($sformatf("cont%0d spacing", r), gq[1].cyc - gq[0].cyc, 4);
      chk($sformatf("cont%0d ic rdata", r), rq[0].rd, {16{8'h01}});
      chk($sformatf("cont%0d dc rdata", r), rq[1].rd, {16{8'h02}});
      clear_logs();
    end
    m_last = REQ_DC;
    for (int i = 0; i < 6; i++) begin
      drive(!vt[i].dc, vt[i].dc, vt[i].addr, vt[i].addr, vt[i].we, vt[i].wd);
      mplan.push_back('{vt[i].lat, vt[i].line});
      collect($sformatf("vec%0d", i), 1, 400);
      chk($sformatf("vec%0d gnt side", i), gq[0].dc, vt[i].dc);
      chk($sformatf("vec%0d gnt latency", i), gq[0].cyc - start, 1);
      chk($sformatf("vec%0d mem_req", i), {gq[0].req, nreq}, {1'b1, 32'd1});
      chk($sformatf("vec%0d mem_addr", i), gq[0].addr, vt[i].x_addr);
      chk($sformatf("vec%0d mem_we", i), gq[0].we, vt[i].x_we);
      if (vt[i].x_we) chk($sformatf("vec%0d mem_wdata", i), gq[0].wd, vt[i].wd);
      chk($sformatf("vec%0d rv side", i), rq[0].dc, vt[i].dc);
      if (!vt[i].x_we) chk($sformatf("vec%0d rdata", i), rq[0].rd, vt[i].x_rdata);
      chk($sformatf("vec%0d err", i), rq[0].err, vt[i].x_err);
      chk($sformatf("vec%0d rv delay", i), rq[0].cyc - gq[0].cyc, vt[i].x_dly);
      m_last = requester_e'(vt[i].dc);
      clear_logs();
    end
    drive(0, 1, 32'h0000_0040, 32'h0000_0040, 0, '0);
    mplan.push_back('{0, '0});
    repeat (6) tick();
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = {16{8'h77}};
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst-wait quiet", rq.size(), 0);
    chk_quiet("rst-wait");
    clear_logs();
    m_last = REQ_DC;
    drive(1, 0, 32'h0000_5678, '0, 0, '0);
    mplan.push_back('{2, {16{8'h9A}}});
    collect("after-rst", 1, 40);
    chk("after-rst side", gq[0].dc, 0);
    chk("after-rst addr", gq[0].addr, 32'h0000_5670);
    chk("after-rst rdata", rq[0].rd, {16{8'h9A}});
    chk("after-rst err", rq[0].err, 0);
    m_last = REQ_IC;
    clear_logs();
    for (int r = 0; r < 30; r++) begin
      bit icr, dcr, we;
      bit ord[2];
      int n, s, xl;
      int lat[2];
      logic [LINE_BITS-1:0] ln[2];
      logic [LINE_BITS-1:0] wd;
      logic [ADDR_W-1:0] ia, da;
      icr = 1'($urandom_range(0, 1));
      dcr = icr ? 1'($urandom_range(0, 1)) : 1'b1;
      we = 1'($urandom_range(0, 1));
      ia = $urandom;
      da = $urandom;
      wd = {$urandom, $urandom, $urandom, $urandom};
      n = int'(icr) + int'(dcr);
      ord[0] = (icr && dcr) ? (m_last == REQ_IC) : dcr;
      ord[1] = !ord[0];
      for (int k = 0; k < n; k++) begin
        s = $urandom_range(0, 19);
        lat[k] = s == 0 ? 0 : s == 1 ? MEM_TIMEOUT : s == 2 ? MEM_TIMEOUT - 1 : int'($urandom_range(1, 8));
        ln[k] = {$urandom, $urandom, $urandom, $urandom};
        mplan.push_back('{lat[k], ln[k]});
      end
      drive(icr, dcr, ia, da, we, wd);
      collect($sformatf("rnd%0d", r), n, 700);
      chk($sformatf("rnd%0d mem_req count", r), nreq, n);
      chk($sformatf("rnd%0d gnt latency", r), gq[0].cyc - start, 1);
      for (int k = 0; k < n; k++) begin
        xl = lat[k] == 0 ? MEM_TIMEOUT : lat[k];
        chk($sformatf("rnd%0d.%0d gnt side", r, k), gq[k].dc, ord[k]);
        chk($sformatf("rnd%0d.%0d rv side", r, k), rq[k].dc, ord[k]);
        chk($sformatf("rnd%0d.%0d addr", r, k), gq[k].addr, (ord[k] ? da : ia) & 32'hFFFF_FFF0);
        chk($sformatf("rnd%0d.%0d we", r, k), gq[k].we, ord[k] && we);
        if (ord[k] && we) chk($sformatf("rnd%0d.%0d wdata", r, k), gq[k].wd, wd);
        else chk($sformatf("rnd%0d.%0d rdata", r, k), rq[k].rd, lat[k] == 0 ? '0 : ln[k]);
        chk($sformatf("rnd%0d.%0d err", r, k), rq[k].err, lat[k] == 0);
        chk($sformatf("rnd%0d.%0d delay", r, k), rq[k].cyc - gq[k].cyc, xl + 1);
        if (k == 1) chk($sformatf("rnd%0d spacing", r), gq[1].cyc - rq[0].cyc, 2);
      end
      m_last = requester_e'(ord[n-1]);
      clear_logs();
    end
    chk("protocol violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
